// File: rtl/debug_flag_sequencer.sv
// Watches the firmware debug word, filters it for stability and walks a programmed
// list of expected flags (with optional follow-up values) to report pass/fail on-chip.
module debug_flag_sequencer #(
   parameter int         DATA_W      = 32,
   parameter int         DEPTH       = 16,
   parameter int         TMO_W       = 16,
   parameter int         STABLE_N    = 2,
   parameter logic [7:0] FAIL_STATUS = 8'hFF,
   localparam int        IDX_W       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] debug_word,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_flag,
   input  logic [DATA_W-1:0] wr_value,
   input  logic              wr_chk,
   input  logic [TMO_W-1:0]  wr_tmo,
   input  logic [IDX_W:0]    seq_len,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [IDX_W-1:0]  fail_idx,
   output logic [1:0]        fail_code,
   output logic [DATA_W-1:0] last_word
);

   localparam int               CNT_W   = $clog2(STABLE_N + 1);
   localparam logic [CNT_W-1:0] RUN_SAT = CNT_W'(STABLE_N);
   localparam logic [CNT_W-1:0] RUN_EVT = CNT_W'(STABLE_N - 1);
   localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);
   localparam logic [IDX_W:0]   LEN_MAX = (IDX_W + 1)'(DEPTH);
   localparam logic [IDX_W:0]   LEN_ONE = (IDX_W + 1)'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

   localparam logic [1:0] CODE_NONE = 2'b00;
   localparam logic [1:0] CODE_FLAG = 2'b01;
   localparam logic [1:0] CODE_VAL  = 2'b10;
   localparam logic [1:0] CODE_STAT = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_FLAG,
      WAIT_VAL,
      DONE
   } state_t;

   // Stability filter: run_q counts consecutive cycles equal to the previous sample.
   logic [DATA_W-1:0] prev_q;
   logic [DATA_W-1:0] last_q;
   logic [CNT_W-1:0]  run_q, run_d;
   logic              same;
   logic              stable_evt;

   always_comb begin
      same       = (debug_word == prev_q);
      run_d      = '0;
      if (same) begin
         run_d = (run_q == RUN_SAT) ? run_q : run_q + RUN_ONE;
      end
      stable_evt = same && (run_q == RUN_EVT) && (debug_word != last_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= '0;
         run_q  <= '0;
         last_q <= '0;
      end else begin
         prev_q <= debug_word;
         run_q  <= run_d;
         if (stable_evt) begin
            last_q <= debug_word;
         end
      end
   end

   // Entry storage; contents survive reset and are frozen while a run is active.
   logic [DATA_W-1:0] flag_mem [DEPTH];
   logic [DATA_W-1:0] val_mem  [DEPTH];
   logic              chk_mem  [DEPTH];
   logic [TMO_W-1:0]  tmo_mem  [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en && !busy) begin
         flag_mem[wr_idx] <= wr_flag;
         val_mem[wr_idx]  <= wr_value;
         chk_mem[wr_idx]  <= wr_chk;
         tmo_mem[wr_idx]  <= wr_tmo;
      end
   end

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W:0]    len_q, len_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [IDX_W-1:0]  fidx_q, fidx_d;
   logic [1:0]        code_q, code_d;

   logic              status_fail;
   logic              expired;
   logic              advance;
   logic              fail_now;
   logic [1:0]        fail_val;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_d    = len_q;
      tmo_d    = tmo_q;
      done_d   = done_q;
      pass_d   = pass_q;
      fidx_d   = fidx_q;
      code_d   = code_q;
      advance  = 1'b0;
      fail_now = 1'b0;
      fail_val = CODE_NONE;

      status_fail = stable_evt && (debug_word[DATA_W-1 -: 8] == FAIL_STATUS);
      expired     = (tmo_q == '0);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               done_d = 1'b0;
               pass_d = 1'b0;
               fidx_d = '0;
               code_d = CODE_NONE;
               idx_d  = '0;
               len_d  = seq_len;
               if ((seq_len == '0) || (seq_len > LEN_MAX)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  code_d  = CODE_FLAG;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (status_fail) begin
               fail_now = 1'b1;
               fail_val = CODE_STAT;
            end else begin
               tmo_d   = tmo_mem[idx_q];
               state_d = WAIT_FLAG;
            end
         end
         WAIT_FLAG: begin
            if (!expired) begin
               tmo_d = tmo_q - TMO_ONE;
            end
            // A match on the final counter cycle still counts.
            if (status_fail) begin
               fail_now = 1'b1;
               fail_val = CODE_STAT;
            end else if (stable_evt && (debug_word == flag_mem[idx_q])) begin
               if (chk_mem[idx_q]) begin
                  tmo_d   = tmo_mem[idx_q];
                  state_d = WAIT_VAL;
               end else begin
                  advance = 1'b1;
               end
            end else if (expired) begin
               fail_now = 1'b1;
               fail_val = CODE_FLAG;
            end
         end
         WAIT_VAL: begin
            if (!expired) begin
               tmo_d = tmo_q - TMO_ONE;
            end
            if (status_fail) begin
               fail_now = 1'b1;
               fail_val = CODE_STAT;
            end else if (stable_evt) begin
               if (debug_word == val_mem[idx_q]) begin
                  advance = 1'b1;
               end else begin
                  fail_now = 1'b1;
                  fail_val = CODE_VAL;
               end
            end else if (expired) begin
               fail_now = 1'b1;
               fail_val = CODE_VAL;
            end
         end
         default: state_d = IDLE;
      endcase

      if (fail_now) begin
         state_d = DONE;
         done_d  = 1'b1;
         pass_d  = 1'b0;
         code_d  = fail_val;
         fidx_d  = idx_q;
      end else if (advance) begin
         if ({1'b0, idx_q} == (len_q - LEN_ONE)) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
         end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = LOAD;
         end
      end

      if (abort) begin
         state_d = IDLE;
         done_d  = 1'b0;
         pass_d  = 1'b0;
         code_d  = CODE_NONE;
         fidx_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         tmo_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fidx_q  <= '0;
         code_q  <= CODE_NONE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         tmo_q   <= tmo_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fidx_q  <= fidx_d;
         code_q  <= code_d;
      end
   end

   assign busy      = (state_q == LOAD) || (state_q == WAIT_FLAG) || (state_q == WAIT_VAL);
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_idx  = fidx_q;
   assign fail_code = code_q;
   assign last_word = last_q;

endmodule

// File: tb/tb_debug_flag_sequencer.sv
// Bench for debug_flag_sequencer: directed vector table, hand-written corner sequences and
// a randomized run, all shadowed cycle by cycle by an event/deadline reference model.
module tb_debug_flag_sequencer;

   localparam int DATA_W   = 32;
   localparam int DEPTH    = 16;
   localparam int TMO_W    = 16;
   localparam int STABLE_N = 2;
   localparam int IDX_W    = 4;

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] debug_word;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_flag;
   logic [DATA_W-1:0] wr_value;
   logic              wr_chk;
   logic [TMO_W-1:0]  wr_tmo;
   logic [IDX_W:0]    seq_len;
   logic              start;
   logic              abort;
   logic              busy;
   logic              done;
   logic              pass;
   logic [IDX_W-1:0]  fail_idx;
   logic [1:0]        fail_code;
   logic [DATA_W-1:0] last_word;

   debug_flag_sequencer #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .TMO_W(TMO_W), .STABLE_N(STABLE_N), .FAIL_STATUS(8'hFF)
   ) dut (
      .clk(clk), .reset(reset), .debug_word(debug_word), .wr_en(wr_en), .wr_idx(wr_idx),
      .wr_flag(wr_flag), .wr_value(wr_value), .wr_chk(wr_chk), .wr_tmo(wr_tmo),
      .seq_len(seq_len), .start(start), .abort(abort), .busy(busy), .done(done), .pass(pass),
      .fail_idx(fail_idx), .fail_code(fail_code), .last_word(last_word)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: stable events from run lengths, timeouts as absolute deadlines.
   longint            cyc = 0;
   logic [DATA_W-1:0] m_prev = '0;
   logic [DATA_W-1:0] m_last = '0;
   int                m_run = 1;
   bit                m_busy = 0, m_loading = 0, m_inval = 0, m_done = 0, m_pass = 0;
   logic [1:0]        m_code = 2'b00;
   int                m_idx = 0, m_fidx = 0, m_len = 0;
   longint            m_deadline = 0;
   logic [DATA_W-1:0] m_flag [DEPTH];
   logic [DATA_W-1:0] m_val  [DEPTH];
   bit                m_chk  [DEPTH];
   int                m_tmo  [DEPTH];

   task automatic model_fail(input logic [1:0] c);
      m_busy = 0; m_loading = 0; m_done = 1; m_pass = 0; m_code = c; m_fidx = m_idx;
   endtask

   task automatic model_advance();
      if (m_idx == m_len - 1) begin
         m_busy = 0; m_done = 1; m_pass = 1;
      end else begin
         m_idx++; m_loading = 1;
      end
   endtask

   task automatic model_edge();
      bit evt;
      bit pre_busy;
      cyc++;
      evt = 0;
      pre_busy = m_busy;
      if (wr_en && !pre_busy) begin
         m_flag[wr_idx] = wr_flag; m_val[wr_idx] = wr_value;
         m_chk[wr_idx] = wr_chk;   m_tmo[wr_idx] = int'(wr_tmo);
      end
      if (reset) begin
         m_prev = '0; m_run = 1; m_last = '0;
         m_busy = 0; m_loading = 0; m_inval = 0; m_done = 0; m_pass = 0;
         m_code = 2'b00; m_fidx = 0; m_idx = 0;
      end else begin
         if (debug_word == m_prev) begin
            if (m_run < 1000) m_run++;
         end else begin
            m_run = 1;
         end
         evt = (m_run == STABLE_N + 1) && (debug_word != m_last);
         m_prev = debug_word;
         if (evt) m_last = debug_word;

         if (abort) begin
            m_busy = 0; m_loading = 0; m_done = 0; m_pass = 0; m_code = 2'b00; m_fidx = 0;
         end else if (!m_busy) begin
            if (start) begin
               m_len = int'(seq_len); m_idx = 0; m_fidx = 0; m_pass = 0;
               if (seq_len == 0 || int'(seq_len) > DEPTH) begin
                  m_done = 1; m_code = 2'b01;
               end else begin
                  m_done = 0; m_code = 2'b00; m_busy = 1; m_loading = 1;
               end
            end
         end else if (evt && debug_word[31:24] == 8'hFF) begin
            model_fail(2'b11);
         end else if (m_loading) begin
            m_loading = 0; m_inval = 0;
            m_deadline = cyc + m_tmo[m_idx] + 1;
         end else if (!m_inval) begin
            if (evt && debug_word == m_flag[m_idx]) begin
               if (m_chk[m_idx]) begin
                  m_inval = 1; m_deadline = cyc + m_tmo[m_idx] + 1;
               end else begin
                  model_advance();
               end
            end else if (cyc == m_deadline) begin
               model_fail(2'b01);
            end
         end else begin
            if (evt) begin
               if (debug_word == m_val[m_idx]) model_advance();
               else model_fail(2'b10);
            end else if (cyc == m_deadline) begin
               model_fail(2'b10);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check($sformatf("model_cycle%0d", cyc),
            {busy, done, pass, fail_idx, fail_code, last_word},
            {m_busy, m_done, m_pass, 4'(m_fidx), m_code, m_last});
   endtask

   task automatic do_reset();
      wr_en = 0; start = 0; abort = 0; debug_word = '0; seq_len = '0;
      reset = 1;
      tick(); tick();
      reset = 0;
   endtask

   task automatic write_entry(input int idx, input logic [31:0] f, input logic [31:0] v,
                              input logic c, input logic [15:0] t);
      wr_en = 1; wr_idx = 4'(idx); wr_flag = f; wr_value = v; wr_chk = c; wr_tmo = t;
      tick();
      wr_en = 0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done) break;
         tick();
      end
   endtask

   typedef struct packed {
      logic [4:0]        len;
      logic [2:0][31:0]  flag;
      logic [2:0][31:0]  val;
      logic [2:0]        chk;
      logic [15:0]       tmo;
      logic [3:0][31:0]  w;
      logic [3:0][3:0]   hold;
      logic              exp_pass;
      logic [1:0]        exp_code;
      logic [3:0]        exp_idx;
      logic [31:0]       exp_last;
   } vec_t;

   function automatic vec_t mk(input logic [4:0] len,
                               input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] f2,
                               input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                               input logic [2:0] chk, input logic [15:0] tmo,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input logic [3:0] h0, input logic [3:0] h1,
                               input logic [3:0] h2, input logic [3:0] h3,
                               input logic ep, input logic [1:0] ec, input logic [3:0] ei,
                               input logic [31:0] el);
      vec_t r;
      r.len = len; r.flag[0] = f0; r.flag[1] = f1; r.flag[2] = f2;
      r.val[0] = v0; r.val[1] = v1; r.val[2] = v2; r.chk = chk; r.tmo = tmo;
      r.w[0] = w0; r.w[1] = w1; r.w[2] = w2; r.w[3] = w3;
      r.hold[0] = h0; r.hold[1] = h1; r.hold[2] = h2; r.hold[3] = h3;
      r.exp_pass = ep; r.exp_code = ec; r.exp_idx = ei; r.exp_last = el;
      return r;
   endfunction

   task automatic run_vec(input int n, input vec_t v);
      do_reset();
      for (int e = 0; e < 3; e++) write_entry(e, v.flag[e], v.val[e], v.chk[e], v.tmo);
      seq_len = v.len; start = 1;
      tick();
      start = 0;
      for (int k = 0; k < 4; k++) begin
         debug_word = v.w[k];
         repeat (int'(v.hold[k])) tick();
      end
      wait_done(300);
      check($sformatf("vec%0d_done", n), 64'(done), 64'(1));
      check($sformatf("vec%0d_pass", n), 64'(pass), 64'(v.exp_pass));
      check($sformatf("vec%0d_code", n), 64'(fail_code), 64'(v.exp_code));
      check($sformatf("vec%0d_idx", n), 64'(fail_idx), 64'(v.exp_idx));
      check($sformatf("vec%0d_last", n), 64'(last_word), 64'(v.exp_last));
   endtask

   function automatic logic [31:0] pick_word();
      logic [31:0] pool [7];
      pool = '{32'h00010001, 32'h00010002, 32'h00010003, 32'h00010004,
               32'h00010005, 32'h00010006, 32'h00000020};
      if ($urandom_range(0, 99) < 3) return 32'hFF000000;
      return pool[$urandom_range(0, 6)];
   endfunction

   vec_t vecs [12];

   initial begin
      vecs[0]  = mk(1, 32'h00010000, 0, 0, 0, 0, 0, 3'b000, 100,
                    32'h00030000, 32'h00010000, 32'h00010000, 32'h00010000, 4, 4, 4, 4,
                    1, 2'b00, 0, 32'h00010000);
      vecs[1]  = mk(2, 32'h00040300, 32'h00040302, 0, 0, 32'h20, 0, 3'b010, 100,
                    32'h00040300, 32'h00040301, 32'h00040302, 32'h00000020, 4, 4, 4, 4,
                    1, 2'b00, 0, 32'h00000020);
      vecs[2]  = mk(2, 32'h00040300, 32'h00040302, 0, 0, 32'h20, 0, 3'b010, 100,
                    32'h00040300, 32'h00040301, 32'h00040302, 32'h00000040, 4, 4, 4, 4,
                    0, 2'b10, 1, 32'h00000040);
      vecs[3]  = mk(1, 32'h00010000, 0, 0, 0, 0, 0, 3'b000, 10,
                    0, 0, 0, 0, 4, 4, 4, 4, 0, 2'b01, 0, 0);
      vecs[4]  = mk(3, 32'h00050001, 32'h00050002, 32'h00050003, 0, 0, 0, 3'b000, 200,
                    32'h00050001, 32'h00050002, 32'hFF000000, 32'hFF000000, 4, 4, 4, 4,
                    0, 2'b11, 2, 32'hFF000000);
      vecs[5]  = mk(1, 32'h00010000, 0, 0, 0, 0, 0, 3'b000, 30,
                    32'h00020000, 32'h00010000, 32'h00020000, 32'h00020000, 4, 1, 4, 1,
                    0, 2'b01, 0, 32'h00020000);
      vecs[6]  = mk(1, 32'h00010000, 0, 0, 0, 0, 0, 3'b000, 30,
                    32'h00020000, 32'h00010000, 32'h00020000, 32'h00020000, 4, 3, 4, 1,
                    1, 2'b00, 0, 32'h00020000);
      vecs[7]  = mk(0, 32'h00010000, 0, 0, 0, 0, 0, 3'b000, 10,
                    0, 0, 0, 0, 1, 1, 1, 1, 0, 2'b01, 0, 0);
      vecs[8]  = mk(17, 32'h00010000, 0, 0, 0, 0, 0, 3'b000, 10,
                    0, 0, 0, 0, 1, 1, 1, 1, 0, 2'b01, 0, 0);
      vecs[9]  = mk(1, 32'h00010005, 0, 0, 32'h00010006, 0, 0, 3'b001, 5,
                    32'h00010005, 32'h00010005, 32'h00010005, 32'h00010005, 4, 4, 4, 4,
                    0, 2'b10, 0, 32'h00010005);
      vecs[10] = mk(1, 32'h00010007, 0, 0, 0, 0, 0, 3'b000, 1,
                    32'h00010007, 32'h00010007, 32'h00010007, 32'h00010007, 4, 4, 4, 4,
                    1, 2'b00, 0, 32'h00010007);
      vecs[11] = mk(1, 32'h00010007, 0, 0, 0, 0, 0, 3'b000, 0,
                    32'h00010007, 32'h00010007, 32'h00010007, 32'h00010007, 4, 4, 4, 4,
                    0, 2'b01, 0, 32'h00010007);

      wr_idx = '0; wr_flag = '0; wr_value = '0; wr_chk = 0; wr_tmo = '0;
      do_reset();
      check("reset_state", {busy, done, pass, fail_idx, fail_code, last_word}, 64'd0);

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // Flag timeout latency: tmo=10 expires on the 12th edge after the start edge.
      do_reset();
      write_entry(0, 32'h00010000, 0, 0, 10);
      seq_len = 1; start = 1;
      tick();
      start = 0;
      repeat (11) tick();
      check("tmo_not_yet", 64'(done), 64'(0));
      tick();
      check("tmo_expired", {done, pass, fail_code, fail_idx}, {1'b1, 1'b0, 2'b01, 4'd0});

      // Abort mid-run.
      do_reset();
      write_entry(0, 32'h00010000, 0, 0, 50);
      seq_len = 1; start = 1;
      tick();
      start = 0;
      repeat (3) tick();
      check("abort_busy_before", 64'(busy), 64'(1));
      abort = 1;
      tick();
      abort = 0;
      check("abort_cleared", {busy, done, pass}, 64'd0);

      // Start and entry writes while busy are ignored.
      do_reset();
      write_entry(0, 32'h00010001, 0, 0, 60);
      seq_len = 1; start = 1;
      tick();
      seq_len = 0; wr_en = 1; wr_idx = 0; wr_flag = 32'h00010002; wr_tmo = 1;
      tick();
      start = 0; wr_en = 0;
      check("start_while_busy", {busy, done}, 64'b10);
      debug_word = 32'h00010001;
      repeat (4) tick();
      wait_done(30);
      check("write_while_busy", {done, pass}, 64'b11);

      // Reset mid-run clears everything, including last_word.
      do_reset();
      write_entry(0, 32'h00010001, 0, 0, 60);
      debug_word = 32'h00030000; seq_len = 1; start = 1;
      tick();
      start = 0;
      repeat (5) tick();
      check("reset_pre", {busy, last_word}, {1'b1, 32'h00030000});
      reset = 1;
      tick();
      reset = 0;
      check("reset_mid_run", {busy, done, pass, fail_idx, fail_code, last_word}, 64'd0);

      // Randomized run against the reference model.
      do_reset();
      for (int e = 0; e < DEPTH; e++)
         write_entry(e, pick_word(), pick_word(), 1'($urandom_range(0, 1)),
                     16'($urandom_range(0, 25)));
      begin
         int hold_left;
         hold_left = 0;
         for (int c = 0; c < 6000; c++) begin
            if (hold_left == 0) begin
               debug_word = pick_word();
               hold_left = $urandom_range(1, 5);
            end
            hold_left--;
            start   = ($urandom_range(0, 29) == 0);
            seq_len = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(1, 4));
            wr_en    = ($urandom_range(0, 9) == 0);
            wr_idx   = 4'($urandom_range(0, DEPTH - 1));
            wr_flag  = pick_word();
            wr_value = pick_word();
            wr_chk   = 1'($urandom_range(0, 1));
            wr_tmo   = 16'($urandom_range(0, 25));
            abort    = ($urandom_range(0, 199) == 0);
            reset    = ($urandom_range(0, 499) == 0);
            tick();
         end
      end
      reset = 0; start = 0; abort = 0; wr_en = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/debug_flag_sequencer.md
Name: debug_flag_sequencer

Overview:
- Synthesizable, parametrised checker that watches the 32-bit debug word driven by the PULPino firmware. The word is laid out as {status, location, id, step}.
- It walks a programmed list of expected flags. Each flag has a timeout and an optional check on the value that follows it.
- It reports pass/fail on-chip, so the directed GPIO/ISR sequences can run on the board as well as in simulation.
- It sits beside the Qsys system, taps debug_wire, and drives LEDR/status registers.

Parameters:
- DATA_W, 32, width of the debug word.
- DEPTH, 16, number of sequence entries; must be a power of two, at least 2.
- TMO_W, 16, width of the per-entry timeout counter.
- STABLE_N, 2, consecutive identical samples needed before a debug word counts as observed.
- FAIL_STATUS, 8'hFF, status byte that aborts the run immediately.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- debug_word  in  DATA_W  firmware debug word.
- wr_en  in  1  write one sequence entry.
- wr_idx  in  log2(DEPTH)  entry index.
- wr_flag  in  DATA_W  expected flag word.
- wr_value  in  DATA_W  expected following value.
- wr_chk  in  1  1 = the value check is enabled for this entry.
- wr_tmo  in  TMO_W  timeout in cycles for this entry.
- seq_len  in  log2(DEPTH)+1  number of active entries, 1..DEPTH; sampled at start.
- start  in  1  one-cycle pulse that begins a run.
- abort  in  1  forces a return to IDLE.
- busy  out  1  a run is in progress.
- done  out  1  the run has finished; held until the next start or reset.
- pass  out  1  valid while done.
- fail_idx  out  log2(DEPTH)  entry index at which the run failed.
- fail_code  out  2  00 none, 01 flag timeout, 10 value mismatch/timeout, 11 FAIL_STATUS seen.
- last_word  out  DATA_W  last stable word observed.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Entry RAM contents are not reset.
- Stability filter:
  - A stable word is declared when debug_word has equalled its previous sample for STABLE_N consecutive cycles.
  - stable_evt pulses once per new stable word; a word equal to the prior stable word produces no new event.
  - last_word updates on stable_evt.
- FSM states: IDLE, LOAD, WAIT_FLAG, WAIT_VAL, DONE.
- IDLE:
  - start takes the FSM to LOAD; seq_len is latched and idx is set to 0.
  - start with seq_len=0 or seq_len>DEPTH goes directly to DONE with pass=0, fail_code=01, fail_idx=0.
- LOAD: one cycle. Reads entry idx, loads the timeout counter with wr_tmo[idx], then moves to WAIT_FLAG. busy=1 from LOAD through WAIT_VAL.
- WAIT_FLAG:
  - The counter decrements every cycle.
  - stable_evt with word == flag: if chk=1, reload the counter and go to WAIT_VAL; otherwise advance.
  - A stable word that does not match is ignored, because intermediate flags are allowed.
  - Counter reaching 0 without a match: fail with code 01.
- WAIT_VAL:
  - The next stable_evt must equal value; otherwise fail with code 10.
  - Counter reaching 0: fail with code 10.
- Advance: if idx==seq_len-1, go to DONE with pass=1. Otherwise increment idx and go to LOAD.
- FAIL_STATUS: a stable word whose status byte [31:24]==FAIL_STATUS aborts the run from any busy state, with code 11. This takes priority over a flag match in the same cycle.
- Simultaneous events:
  - A match in the same cycle the counter reaches 0 counts as a match.
  - abort has priority over everything: return to IDLE, done=0, pass=0.
  - start while busy is ignored.
- Latency:
  - done asserts 1 cycle after the deciding stable_evt or the timeout.
  - stable_evt itself lags a debug_word change by STABLE_N cycles.
- Writes:
  - wr_en while busy is ignored.
  - While idle, a write is visible to the next run.
- Reset mid-run: returns to IDLE with all outputs cleared within 1 cycle.

Test Plan:
1. Single-entry pass: 1 entry, flag 0x00010000, tmo=100, chk=0; drive 0x00030000 then 0x00010000 (each held 4 cycles) -> done=1, pass=1, last_word=0x00010000.
2. ISR value check: 2 entries.
   - Entry 0: flag 0x00040300, chk=0.
   - Entry 1: flag 0x00040302, chk=1, value 0x00000020.
   - Drive 0x00040300, 0x00040301, 0x00040302, 0x00000020 -> pass=1.
   - Repeat with a final word of 0x00000040 -> fail_code=10, fail_idx=1.
3. Flag timeout: tmo=10, debug_word held at 0 -> done about 11 cycles after LOAD, fail_code=01, fail_idx=0.
4. Failure status: drive 0xFF000000 during WAIT_FLAG of entry 2 -> fail_code=11, fail_idx=2, regardless of the timeout left.
5. Glitch filter with STABLE_N=2: a 1-cycle pulse of the expected flag -> no match, eventual fail_code=01. The same pulse held 3 cycles -> match.
6. Control edge cases:
   - abort mid-run -> busy=0, done=0 next cycle.
   - reset mid-run -> all outputs 0.
   - start with seq_len=0 -> done=1, pass=0, fail_code=01.
